// File: rtl/adder_err_acc_i8_o5_if.sv
// Sample/control bundle for the 4-bit adder error accumulator.
// master = stimulus side, slave = accumulator side.
interface adder_err_acc_i8_o5_if #(
    parameter int SUM_W = 16
);
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opa;
    logic [3:0]       opb;
    logic [4:0]       approx;
    logic             busy;
    logic             done;
    logic [8:0]       sample_cnt;
    logic [8:0]       err_cnt;
    logic [SUM_W-1:0] err_sum;
    logic [4:0]       err_max;

    modport master (
        output start, in_valid, opa, opb, approx,
        input  in_ready, busy, done, sample_cnt, err_cnt, err_sum, err_max
    );

    modport slave (
        input  start, in_valid, opa, opb, approx,
        output in_ready, busy, done, sample_cnt, err_cnt, err_sum, err_max
    );
endinterface

// File: rtl/adder_err_acc_i8_o5.sv
// Error-statistics accumulator for an approximate 4-bit adder: counts samples,
// erroneous sums, total and worst-case error distance over one evaluation run.
module adder_err_acc_i8_o5_ed (
    input  logic [4:0] exact,
    input  logic [4:0] approx,
    output logic [4:0] ed
);
    assign ed = (approx >= exact) ? (approx - exact) : (exact - approx);
endmodule

module adder_err_acc_i8_o5 #(
    parameter int N_SAMPLES = 256,
    parameter int SUM_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    adder_err_acc_i8_o5_if.slave bus
);
    localparam int STAGES = 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [4:0] exact;
        logic [4:0] approx;
    } s1_t;

    state_t           state;
    logic             in_ready_q, busy_q, done_q;
    logic [8:0]       sample_cnt_q;
    logic [8:0]       err_cnt_q;
    logic [SUM_W-1:0] err_sum_q;
    logic [4:0]       err_max_q;

    logic [STAGES:1]  vld_q;
    logic [STAGES:0]  vld_pipe;
    s1_t              s1;
    logic [4:0]       ed_c, ed_q;
    logic [SUM_W:0]   sum_ext;

    logic acc, start_go, last;

    assign acc      = bus.in_valid & in_ready_q;
    assign start_go = bus.start & ((state == IDLE) || (state == DONE));
    assign last     = (sample_cnt_q == 9'(N_SAMPLES - 1));
    assign vld_pipe = {vld_q, acc};

    // Control FSM; in_ready/busy/done are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sample_cnt_q <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state        <= RUN;
                        in_ready_q   <= 1'b1;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        sample_cnt_q <= '0;
                    end
                end
                RUN: begin
                    if (acc) begin
                        sample_cnt_q <= sample_cnt_q + 9'd1;
                        if (last) begin
                            state      <= DRAIN;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // Stage 2 retires on this edge once stage 1 is empty.
                    if (!vld_pipe[1]) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            s1    <= '0;
            ed_q  <= '0;
        end else begin
            vld_q <= vld_pipe[STAGES-1:0];
            if (acc) begin
                s1.exact  <= {1'b0, bus.opa} + {1'b0, bus.opb};
                s1.approx <= bus.approx;
            end
            if (vld_pipe[1]) ed_q <= ed_c;
        end
    end

    adder_err_acc_i8_o5_ed u_ed (
        .exact  (s1.exact),
        .approx (s1.approx),
        .ed     (ed_c)
    );

    assign sum_ext = {1'b0, err_sum_q} + (SUM_W+1)'(ed_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
            err_sum_q <= '0;
            err_max_q <= '0;
        end else if (start_go) begin
            err_cnt_q <= '0;
            err_sum_q <= '0;
            err_max_q <= '0;
        end else if (vld_pipe[STAGES]) begin
            if (ed_q != 5'd0) err_cnt_q <= err_cnt_q + 9'd1;
            err_sum_q <= sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
            if (ed_q > err_max_q) err_max_q <= ed_q;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.sample_cnt = sample_cnt_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.err_sum    = err_sum_q;
    assign bus.err_max    = err_max_q;
endmodule
